// File: rtl/data_bus_router_pkg.sv
// data_bus_router_pkg: shared FSM states, target encodings and request legality check for the data bus router
package data_bus_router_pkg;
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    localparam logic TARGET_MEM = 1'b0;
    localparam logic TARGET_PER = 1'b1;
    localparam int ADDR_SEL_BIT = 31;
    function automatic logic is_illegal(input logic rd, input logic wr, input logic [1:0] addr_lo);
        return (rd && wr) || (addr_lo != 2'b00);
    endfunction
endpackage

// File: rtl/data_bus_router_if.sv
// data_bus_router_if: CPU request/response bus plus data RAM and peripheral target buses
//   slave  : the router's view (CPU request and target read data in, everything else out)
//   master : the environment's view (CPU and the two targets)
interface data_bus_router_if;
    logic        cpu_read_i;
    logic        cpu_write_i;
    logic [31:0] cpu_address_i;
    logic [31:0] cpu_write_data_i;
    logic [31:0] cpu_read_data_o;
    logic        cpu_stall_o;
    logic        cpu_fault_o;
    logic        mem_read_enable_o;
    logic        mem_write_enable_o;
    logic [30:0] mem_address_o;
    logic [31:0] mem_data_out_o;
    logic [31:0] mem_data_in_i;
    logic        per_read_enable_o;
    logic        per_write_enable_o;
    logic [30:0] per_address_o;
    logic [31:0] per_data_out_o;
    logic [31:0] per_data_in_i;
    modport slave (
        input  cpu_read_i, cpu_write_i, cpu_address_i, cpu_write_data_i, mem_data_in_i, per_data_in_i,
        output cpu_read_data_o, cpu_stall_o, cpu_fault_o,
               mem_read_enable_o, mem_write_enable_o, mem_address_o, mem_data_out_o,
               per_read_enable_o, per_write_enable_o, per_address_o, per_data_out_o
    );
    modport master (
        output cpu_read_i, cpu_write_i, cpu_address_i, cpu_write_data_i, mem_data_in_i, per_data_in_i,
        input  cpu_read_data_o, cpu_stall_o, cpu_fault_o,
               mem_read_enable_o, mem_write_enable_o, mem_address_o, mem_data_out_o,
               per_read_enable_o, per_write_enable_o, per_address_o, per_data_out_o
    );
endinterface

// File: rtl/data_bus_router.sv
// data_bus_router: routes CPU loads/stores to data RAM (addr[31]=0) or peripherals (addr[31]=1), stalling until done
//   clk_i   : clock, all state on rising edge
//   rst_n_i : asynchronous active-low reset
//   bus     : slave side of data_bus_router_if (CPU request/response, RAM and peripheral buses)
module data_bus_router
    import data_bus_router_pkg::*;
#(
    parameter int MEM_READ_LATENCY = 1,
    parameter int PER_READ_LATENCY = 1
) (
    input logic             clk_i,
    input logic             rst_n_i,
    data_bus_router_if.slave bus
);
    state_t      state_q, state_d;
    logic        rd_q, rd_d;
    logic        tgt_q, tgt_d;
    logic [30:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        req, bad, accept, access;

    assign req    = bus.cpu_read_i || bus.cpu_write_i;
    assign bad    = is_illegal(bus.cpu_read_i, bus.cpu_write_i, bus.cpu_address_i[1:0]);
    assign accept = (state_q == IDLE) && req && !bad;
    assign access = (state_q == ACCESS);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            rd_q    <= 1'b0;
            tgt_q   <= TARGET_MEM;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
            tgt_q   <= tgt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rd_d    = rd_q;
        tgt_d   = tgt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (accept) begin
                state_d = ACCESS;
                rd_d    = bus.cpu_read_i;
                tgt_d   = bus.cpu_address_i[ADDR_SEL_BIT];
                addr_d  = bus.cpu_address_i[30:0];
                wdata_d = bus.cpu_write_data_i;
                // writes take a single strobe cycle; reads wait out the target's latency
                cnt_d   = !bus.cpu_read_i ? 3'd1 :
                          (bus.cpu_address_i[ADDR_SEL_BIT] == TARGET_PER) ? 3'(PER_READ_LATENCY) : 3'(MEM_READ_LATENCY);
            end
            ACCESS: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    state_d = DONE;
                    if (rd_q)
                        rdata_d = (tgt_q == TARGET_PER) ? bus.per_data_in_i : bus.mem_data_in_i;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // stall/fault are combinational on the request, so gate them with reset to keep outputs 0 during reset
    always_comb begin
        bus.cpu_stall_o        = rst_n_i && (access || accept);
        bus.cpu_fault_o        = rst_n_i && (state_q == IDLE) && req && bad;
        bus.cpu_read_data_o    = rdata_q;
        bus.mem_read_enable_o  = access && rd_q && (tgt_q == TARGET_MEM);
        bus.mem_write_enable_o = access && !rd_q && (tgt_q == TARGET_MEM);
        bus.per_read_enable_o  = access && rd_q && (tgt_q == TARGET_PER);
        bus.per_write_enable_o = access && !rd_q && (tgt_q == TARGET_PER);
        bus.mem_address_o      = (access && tgt_q == TARGET_MEM) ? addr_q : '0;
        bus.mem_data_out_o     = (access && tgt_q == TARGET_MEM) ? wdata_q : '0;
        bus.per_address_o      = (access && tgt_q == TARGET_PER) ? addr_q : '0;
        bus.per_data_out_o     = (access && tgt_q == TARGET_PER) ? wdata_q : '0;
    end
endmodule

// File: tb/tb_data_bus_router.sv
// tb_data_bus_router: directed and random request sequences checked against a per-transaction timing model
module tb_data_bus_router;
    localparam int MEM_LAT = 3;
    localparam int PER_LAT = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_rd = '0;

    data_bus_router_if bus();

    data_bus_router #(.MEM_READ_LATENCY(MEM_LAT), .PER_READ_LATENCY(PER_LAT)) dut (
        .clk_i  (clk),
        .rst_n_i(rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input logic stall, input logic fault, input logic mr, input logic mw,
                           input logic pr, input logic pw, input logic [30:0] ma, input logic [30:0] pa,
                           input logic [31:0] md, input logic [31:0] pd);
        chk("stall", {31'd0, bus.cpu_stall_o}, {31'd0, stall});
        chk("fault", {31'd0, bus.cpu_fault_o}, {31'd0, fault});
        chk("strobes", {28'd0, bus.mem_read_enable_o, bus.mem_write_enable_o, bus.per_read_enable_o,
            bus.per_write_enable_o}, {28'd0, mr, mw, pr, pw});
        chk("mem_addr", {1'b0, bus.mem_address_o}, {1'b0, ma});
        chk("per_addr", {1'b0, bus.per_address_o}, {1'b0, pa});
        chk("mem_dout", bus.mem_data_out_o, md);
        chk("per_dout", bus.per_data_out_o, pd);
        chk("rdata", bus.cpu_read_data_o, exp_rd);
    endtask

    task automatic idle();
        @(posedge clk); #1;
        bus.cpu_read_i = 1'b0;
        bus.cpu_write_i = 1'b0;
        bus.cpu_address_i = $urandom;
        bus.cpu_write_data_i = $urandom;
        @(negedge clk);
        chk_all(0, 0, 0, 0, 0, 0, '0, '0, '0, '0);
    endtask

    // Cycle 0 = request first presented. A legal request strobes in cycles 1..lat, completes in lat+1;
    // the target presents valid read data only in the cycle its strobe has been high for lat cycles.
    task automatic do_req(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] v);
        logic bad, t, on;
        int lat;
        bad = (rd && wr) || (a[1:0] != 2'b00);
        t = a[31];
        lat = rd ? (t ? PER_LAT : MEM_LAT) : 1;
        @(posedge clk); #1;
        bus.cpu_read_i = rd;
        bus.cpu_write_i = wr;
        bus.cpu_address_i = a;
        bus.cpu_write_data_i = wd;
        bus.mem_data_in_i = ~v;
        bus.per_data_in_i = ~v;
        @(negedge clk);
        chk_all(!bad, bad, 0, 0, 0, 0, '0, '0, '0, '0);
        if (bad) return;
        for (int k = 1; k <= lat + 1; k++) begin
            @(posedge clk); #1;
            bus.mem_data_in_i = (k == lat && !t) ? v : ~v;
            bus.per_data_in_i = (k == lat && t) ? v : ~v;
            if (k == lat + 1 && rd) exp_rd = v;
            on = (k <= lat);
            @(negedge clk);
            chk_all(on, 0, on && rd && !t, on && !rd && !t, on && rd && t, on && !rd && t,
                    (on && !t) ? a[30:0] : '0, (on && t) ? a[30:0] : '0,
                    (on && !t) ? wd : '0, (on && t) ? wd : '0);
        end
    endtask

    initial begin
        logic [31:0] a;
        logic rd, wr;
        bus.cpu_read_i = 1'b0;
        bus.cpu_write_i = 1'b0;
        bus.cpu_address_i = '0;
        bus.cpu_write_data_i = '0;
        bus.mem_data_in_i = '0;
        bus.per_data_in_i = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_all(0, 0, 0, 0, 0, 0, '0, '0, '0, '0);
        rst_n = 1'b1;
        idle();
        do_req(1, 0, 32'h8000_0000, 32'h0, 32'h1);
        do_req(0, 1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0);
        idle();
        do_req(1, 0, 32'h8000_0002, 32'h0, 32'h5);
        idle();
        do_req(1, 1, 32'h0000_0008, 32'h1234, 32'h6);
        do_req(1, 0, 32'h0000_0004, 32'h0, 32'h1234_5678);
        // reset in the middle of a RAM read
        @(posedge clk); #1;
        bus.cpu_read_i = 1'b1;
        bus.cpu_address_i = 32'h0000_000C;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("mid_read_strobe", {31'd0, bus.mem_read_enable_o}, 32'd1);
        rst_n = 1'b0;
        exp_rd = '0;
        #1;
        chk_all(0, 0, 0, 0, 0, 0, '0, '0, '0, '0);
        bus.cpu_read_i = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle();
        do_req(0, 1, 32'h8000_0020, 32'hCAFE_F00D, 32'h0);
        do_req(1, 0, 32'h0000_0008, 32'h0, 32'hA5A5_0F0F);
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            if ($urandom_range(3) != 0) a[1:0] = 2'b00;
            rd = 1'($urandom_range(1));
            wr = ($urandom_range(7) == 0) ? 1'b1 : !rd;
            do_req(rd, wr, a, $urandom, $urandom);
            if ($urandom_range(2) == 0) idle();
        end
        idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
